pc_sequencer: RTL and testbench

Program-counter sequencer for the core's fetch path. It holds the PC, steps it once per instruction, and applies branch targets returned by the branch-target lookup table. Targets are either PC-relative signed offsets or absolute line numbers. It sits between the instruction decoder (branch/halt/stall controls) and instruction memory (PC output), and runs a start/done handshake with the testbench/top level.

---
 rtl/pc_seq_pkg.sv | 16 +
 rtl/sat_counter.sv | 23 ++
 rtl/pc_sequencer.sv | 99 +++++++++
 tb/tb_pc_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and sizing for the fetch-path program-counter sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int PC_W  = 12;
    localparam int IDX_W = 6;
    localparam int CNT_W = 16;

    localparam logic [PC_W-1:0] PC_RESET = '0;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; used for the retired-instruction count.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: steps the PC, applies relative/absolute branch targets from an
// external LUT, and runs the start/done handshake with the top level.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stall,
    input  logic                 branch_take,
    input  logic                 branch_abs,
    input  logic [IDX_W-1:0]     branch_idx,
    input  logic                 halt,
    output logic [IDX_W-1:0]     lut_addr,
    input  logic [PC_W-1:0]      lut_target,
    output logic [PC_W-1:0]      pc,
    output logic                 running,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] instr_cnt
);

    state_t          state;
    logic [PC_W-1:0] pc_next;
    logic            restart;
    logic            retire;
    logic            in_run;

    assign lut_addr = branch_idx;

    // Relative targets are signed offsets; a D-bit add with the carry dropped gives the
    // two's-complement wrap for free.
    always_comb begin
        pc_next = pc + PC_W'(1);
        if (branch_take) begin
            pc_next = branch_abs ? lut_target : (pc + lut_target);
        end
    end

    assign in_run  = (state == RUN);
    assign restart = ((state == IDLE) || (state == DONE)) && start;
    assign retire  = halt || !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= PC_RESET;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                        pc      <= PC_RESET;
                    end
                end
                // Halt outranks stall and branch; a stalled cycle freezes everything.
                RUN: begin
                    if (halt) begin
                        state   <= DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else if (!stall) begin
                        pc <= pc_next;
                    end
                end
                DONE: begin
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                        done    <= 1'b0;
                        pc      <= PC_RESET;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    done    <= 1'b0;
                    pc      <= PC_RESET;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (restart),
        .inc    (retire),
        .enable (in_run),
        .count  (instr_cnt)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer; a narrow-counter second instance exercises saturation.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    typedef struct {
        logic              start;
        logic              stall;
        logic              take;
        logic              absMode;
        logic [IDX_W-1:0]  idx;
        logic              halt;
        logic [PC_W-1:0]   expPc;
        logic [CNT_W-1:0]  expCnt;
        logic              expRun;
        logic              expDone;
    } vec_t;

    localparam int NVEC = 30;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              stall;
    logic              branchTake;
    logic              branchAbs;
    logic [IDX_W-1:0]  branchIdx;
    logic              halt;
    logic [IDX_W-1:0]  lutAddr;
    logic [PC_W-1:0]   lutTarget;
    logic [PC_W-1:0]   pc;
    logic              running;
    logic              done;
    logic [CNT_W-1:0]  instrCnt;

    logic [IDX_W-1:0]  lutAddrS;
    logic [PC_W-1:0]   lutTargetS;
    logic [PC_W-1:0]   pcS;
    logic              runningS;
    logic              doneS;
    logic [3:0]        instrCntS;

    logic [PC_W-1:0]   lut [64];
    vec_t              vecs [NVEC];

    int nVectors;
    int nMiscompares;

    assign lutTarget  = lut[lutAddr];
    assign lutTargetS = lut[lutAddrS];

    pc_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stall       (stall),
        .branch_take (branchTake),
        .branch_abs  (branchAbs),
        .branch_idx  (branchIdx),
        .halt        (halt),
        .lut_addr    (lutAddr),
        .lut_target  (lutTarget),
        .pc          (pc),
        .running     (running),
        .done        (done),
        .instr_cnt   (instrCnt)
    );

    pc_sequencer #(
        .CNT_WIDTH (4)
    ) dutSmall (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stall       (stall),
        .branch_take (branchTake),
        .branch_abs  (branchAbs),
        .branch_idx  (branchIdx),
        .halt        (halt),
        .lut_addr    (lutAddrS),
        .lut_target  (lutTargetS),
        .pc          (pcS),
        .running     (runningS),
        .done        (doneS),
        .instr_cnt   (instrCntS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(int s, int st, int t, int a, int idx, int h,
                                int expPc, int expCnt, int r, int d);
        vec_t v;
        v.start   = s[0];
        v.stall   = st[0];
        v.take    = t[0];
        v.absMode = a[0];
        v.idx     = IDX_W'(idx);
        v.halt    = h[0];
        v.expPc   = PC_W'(expPc);
        v.expCnt  = CNT_W'(expCnt);
        v.expRun  = r[0];
        v.expDone = d[0];
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        start      = v.start;
        stall      = v.stall;
        branchTake = v.take;
        branchAbs  = v.absMode;
        branchIdx  = v.idx;
        halt       = v.halt;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        start      = 1'b0;
        stall      = 1'b0;
        branchTake = 1'b0;
        branchAbs  = 1'b0;
        branchIdx  = '0;
        halt       = 1'b0;
    endtask

    initial begin
        nVectors     = 0;
        nMiscompares = 0;
        for (int i = 0; i < 64; i++) lut[i] = '0;
        lut[1] = 12'd6;
        lut[2] = 12'hFF7;
        lut[3] = 12'd100;
        lut[4] = 12'd0;
        lut[5] = 12'd4094;
        lut[6] = 12'd4095;
        lut[7] = 12'd3;

        // Each row: inputs for one cycle, then the state seen just after the next rising edge.
        vecs[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 10; i++) vecs[i] = mk(0, 0, 0, 0, 0, 0, i, i, 1, 0);
        vecs[11] = mk(0, 0, 1, 0, 1, 0, 16, 11, 1, 0);
        vecs[12] = mk(0, 0, 1, 0, 2, 0, 7, 12, 1, 0);
        vecs[13] = mk(0, 0, 1, 1, 3, 0, 100, 13, 1, 0);
        vecs[14] = mk(0, 0, 1, 0, 4, 0, 100, 14, 1, 0);
        vecs[15] = mk(0, 1, 1, 0, 1, 0, 100, 14, 1, 0);
        vecs[16] = mk(0, 1, 1, 0, 1, 0, 100, 14, 1, 0);
        vecs[17] = mk(0, 0, 1, 0, 1, 1, 100, 15, 0, 1);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 100, 15, 0, 1);
        vecs[19] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[20] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        vecs[21] = mk(1, 0, 0, 0, 0, 0, 2, 2, 1, 0);
        vecs[22] = mk(0, 1, 0, 0, 0, 1, 2, 3, 0, 1);
        vecs[23] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vecs[24] = mk(0, 0, 1, 1, 5, 0, 4094, 1, 1, 0);
        vecs[25] = mk(0, 0, 1, 0, 1, 0, 4, 2, 1, 0);
        vecs[26] = mk(0, 0, 1, 1, 6, 0, 4095, 3, 1, 0);
        vecs[27] = mk(0, 0, 0, 0, 0, 0, 0, 4, 1, 0);
        vecs[28] = mk(0, 0, 1, 1, 7, 0, 3, 5, 1, 0);
        vecs[29] = mk(0, 0, 1, 0, 2, 0, 4090, 6, 1, 0);

        rst_n = 1'b0;
        idleInputs();
        repeat (3) step();
        checkOutput("reset pc", 32'(pc), 32'd0);
        checkOutput("reset instr_cnt", 32'(instrCnt), 32'd0);
        checkOutput("reset running", 32'(running), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        rst_n = 1'b1;
        step();
        checkOutput("idle pc", 32'(pc), 32'd0);
        checkOutput("idle running", 32'(running), 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d lut_addr", i), 32'(lutAddr), 32'(vecs[i].idx));
            step();
            checkOutput($sformatf("v%0d pc", i), 32'(pc), 32'(vecs[i].expPc));
            checkOutput($sformatf("v%0d instr_cnt", i), 32'(instrCnt), 32'(vecs[i].expCnt));
            checkOutput($sformatf("v%0d running", i), 32'(running), 32'(vecs[i].expRun));
            checkOutput($sformatf("v%0d done", i), 32'(done), 32'(vecs[i].expDone));
        end

        // Reset mid-run must clear outputs before the next clock edge.
        idleInputs();
        repeat (2) step();
        checkOutput("pre-reset pc", 32'(pc), 32'd4092);
        checkOutput("pre-reset instr_cnt", 32'(instrCnt), 32'd8);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset pc", 32'(pc), 32'd0);
        checkOutput("async reset instr_cnt", 32'(instrCnt), 32'd0);
        checkOutput("async reset running", 32'(running), 32'd0);
        checkOutput("async reset done", 32'(done), 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Saturation: the 4-bit instance tops out at 15 while the full-width one keeps counting.
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (14) step();
        checkOutput("sat pre cnt small", 32'(instrCntS), 32'd14);
        checkOutput("sat pre cnt main", 32'(instrCnt), 32'd14);
        for (int k = 1; k <= 3; k++) begin
            step();
            checkOutput($sformatf("sat cnt small +%0d", k), 32'(instrCntS), 32'd15);
            checkOutput($sformatf("sat cnt main +%0d", k), 32'(instrCnt), 32'(14 + k));
        end
        checkOutput("sat pc small", 32'(pcS), 32'd17);
        checkOutput("sat running small", 32'(runningS), 32'd1);
        checkOutput("sat done small", 32'(doneS), 32'd0);
        checkOutput("sat lut_addr small", 32'(lutAddrS), 32'd0);

        // Halting from a saturated count keeps it pinned.
        halt = 1'b1;
        step();
        halt = 1'b0;
        checkOutput("sat halt cnt small", 32'(instrCntS), 32'd15);
        checkOutput("sat halt done small", 32'(doneS), 32'd1);
        checkOutput("sat halt pc", 32'(pc), 32'd17);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
